boot_loader: RTL

Boot-time sequencer for the single-port unified memory shared with the `risc_v` core. It holds the core in reset and receives a program image as a byte stream, for example from a UART receiver. It writes the image word-by-word into memory through the same port the core later uses, then releases the core to execute from address `BASE_ADDR`. Between core and memory it acts as a 2:1 owner mux: the loader owns the write side while loading, and the core owns the port in RUN.

---
 rtl/boot_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Boot-time sequencer for the unified single-port memory shared with the core.
// The core is held in reset while a program image arrives as a byte stream.
// The image is written word-by-word through the core's own memory port, and
// then the core is released to execute from BASE_ADDR. In RUN the block turns
// into a transparent pass-through from the core to the memory.
//
// Stream format (little-endian): 4-byte word count N, then N words of 4 bytes,
// LSB first. N == 0 or N > MAX_WORDS is rejected with a sticky error.
//
// Parameters
//   BASE_ADDR        byte address of image word 0 (word-aligned)
//   MAX_WORDS        largest accepted image, in 32-bit words
//
// Ports
//   clk              clock
//   reset_n          synchronous, active-low reset
//   rx_valid/rx_data byte stream in; a byte moves when rx_valid & rx_ready
//   rx_ready         loader accepts a byte this cycle
//   reload           single-cycle pulse, restarts loading from RUN or ERROR
//   core_reset_n     registered active-low reset to the core (high only in RUN)
//   core_mem_*       core-side memory requests (write side and read address)
//   mem_*            memory port; loader owns the write side while loading
//   busy             high in HDR/DATA/WRITE
//   error            header rejected; sticky until reload or reset
// -----------------------------------------------------------------------------
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        core_reset_n,
    input  logic        core_mem_wen,
    input  logic [31:0] core_mem_wa,
    input  logic [31:0] core_mem_wd,
    input  logic [2:0]  core_mem_funct3,
    input  logic [31:0] core_mem_ra,
    output logic        mem_wen,
    output logic [31:0] mem_wa,
    output logic [31:0] mem_wd,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_ra,
    output logic        busy,
    output logic        error
);

    localparam int         IDX_W     = $clog2(MAX_WORDS + 1);
    localparam logic [2:0] FUNCT3_SW = 3'b010;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t             state_q,        state_d;
    logic [1:0]         byte_cnt_q,     byte_cnt_d;
    logic [31:0]        asm_q,          asm_d;
    logic [IDX_W-1:0]   n_q,            n_d;
    logic [IDX_W-1:0]   word_idx_q,     word_idx_d;
    logic               error_q,        error_d;
    logic               core_reset_n_q, core_reset_n_d;

    logic               rx_fire;
    logic               run;
    logic               hdr_bad;
    logic [31:0]        asm_next;
    logic [IDX_W-1:0]   word_idx_inc;
    logic [31:0]        write_addr;

    assign rx_fire      = rx_valid && rx_ready;
    assign run          = (state_q == S_RUN);

    // Bytes shift in from the top, so after four bytes byte k sits in
    // bits [8k+7:8k]. The same register assembles the header and data words.
    assign asm_next     = {rx_data, asm_q[31:8]};
    assign hdr_bad      = (asm_next == 32'd0) || (asm_next > 32'(MAX_WORDS));
    assign word_idx_inc = word_idx_q + IDX_W'(1);

    // 32-bit arithmetic: an image near the top of the address space wraps.
    assign write_addr   = BASE_ADDR + (32'(word_idx_q) << 2);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;

        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (hdr_bad) begin
                            state_d = S_ERROR;
                        end else begin
                            n_d        = asm_next[IDX_W-1:0];
                            word_idx_d = '0;
                            state_d    = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == n_q) ? S_RUN : S_DATA;
            end
            S_RUN, S_ERROR: begin
                if (reload) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    // Registered status follows the state being entered, so core_reset_n is
    // high from the first RUN cycle and drops the cycle after a reload.
    assign error_d        = (state_d == S_ERROR);
    assign core_reset_n_d = (state_d == S_RUN);

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous to match the rest of this codebase, so it is
    // sampled only on the clock edge and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop updating from the
        // values of the previous cycle, independent of statement order.
        if (!reset_n) begin
            state_q        <= S_HDR;
            byte_cnt_q     <= 2'd0;
            asm_q          <= 32'd0;
            n_q            <= '0;
            word_idx_q     <= '0;
            error_q        <= 1'b0;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            asm_q          <= asm_d;
            n_q            <= n_d;
            word_idx_q     <= word_idx_d;
            error_q        <= error_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs and memory-port owner mux
    // -------------------------------------------------------------------------
    // rx_ready and mem_wen are gated by reset_n directly so a reset asserted
    // mid-load blocks the handshake and any write in that same cycle.
    assign rx_ready     = reset_n && ((state_q == S_HDR) || (state_q == S_DATA));
    assign mem_wen      = reset_n && (run ? core_mem_wen : (state_q == S_WRITE));
    assign mem_wa       = run ? core_mem_wa     : write_addr;
    assign mem_wd       = run ? core_mem_wd     : asm_q;
    assign mem_funct3   = run ? core_mem_funct3 : FUNCT3_SW;

    // The core sits in reset outside RUN, so its read address is harmless to
    // pass through unconditionally.
    assign mem_ra       = core_mem_ra;

    assign busy         = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign error        = error_q;
    assign core_reset_n = core_reset_n_q;

endmodule
